// File: rtl/mem_arbiter.sv
// Two-requester cache-line burst arbiter: grants the I-cache or D-cache a
// four-word memory burst, round-robin when both are pending.
module mem_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_rvalid,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [1:0]        dc_widx,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_rvalid,
  output logic              dc_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, GNT_IC, GNT_DC} state_t;

  localparam logic [1:0] CNT_LAST = 2'(LINE_WORDS - 1);

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                last_dc_q, last_dc_d;
  logic [ADDR_W-5:0]   line_q, line_d;
  logic                we_q, we_d;
  logic                granted;
  logic                last_word;
  logic                unused_addr_bits;

  // Word offset within a line comes from cnt, so the low address bits are dropped.
  assign unused_addr_bits = ^{ic_addr[3:0], dc_addr[3:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_dc_d = last_dc_q;
    line_d    = line_q;
    we_d      = we_q;
    case (state_q)
      IDLE: begin
        // D-cache wins a tie unless it owned the last completed burst.
        if (dc_req && (!ic_req || !last_dc_q)) begin
          state_d = GNT_DC;
          cnt_d   = 2'd0;
          line_d  = dc_addr[ADDR_W-1:4];
          we_d    = dc_we;
        end else if (ic_req) begin
          state_d = GNT_IC;
          cnt_d   = 2'd0;
          line_d  = ic_addr[ADDR_W-1:4];
          we_d    = 1'b0;
        end
      end
      GNT_IC, GNT_DC: begin
        if (mem_ack) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == CNT_LAST) begin
            state_d   = IDLE;
            last_dc_d = (state_q == GNT_DC);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      last_dc_q <= 1'b0;
      line_q    <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_dc_q <= last_dc_d;
      line_q    <= line_d;
      we_q      <= we_d;
    end
  end

  assign granted   = (state_q != IDLE);
  // A final ack landing on a reset edge is discarded, so it must not signal done.
  assign last_word = mem_ack && (cnt_q == CNT_LAST) && !rst;

  assign mem_req   = granted;
  assign mem_we    = (state_q == GNT_DC) && we_q;
  assign mem_addr  = granted ? {line_q, cnt_q, 2'b00} : '0;
  assign mem_wdata = granted ? dc_wdata : '0;
  assign dc_widx   = cnt_q;

  assign ic_rdata  = mem_rdata;
  assign dc_rdata  = mem_rdata;
  assign ic_rvalid = (state_q == GNT_IC) && mem_ack;
  assign dc_rvalid = (state_q == GNT_DC) && mem_ack && !we_q;
  assign ic_done   = (state_q == GNT_IC) && last_word;
  assign dc_done   = (state_q == GNT_DC) && last_word;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single bursts, round-robin, write-back,
// wait states, and reset mid-burst.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic [31:0] ic_rdata;
  logic        ic_rvalid;
  logic        ic_done;
  logic        dc_req;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic [1:0]  dc_widx;
  logic [31:0] dc_rdata;
  logic        dc_rvalid;
  logic        dc_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        wb_mode;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.LINE_WORDS(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_rdata  (ic_rdata),
    .ic_rvalid (ic_rvalid),
    .ic_done   (ic_done),
    .dc_req    (dc_req),
    .dc_we     (dc_we),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_widx   (dc_widx),
    .dc_rdata  (dc_rdata),
    .dc_rvalid (dc_rvalid),
    .dc_done   (dc_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-back source and a memory whose read data is a fixed function of address.
  assign dc_wdata  = wb_mode ? (32'h0000_00A0 + {30'd0, dc_widx}) : 32'h0;
  assign mem_rdata = mem_addr ^ 32'h5A5A_0000;

  task automatic applyStimulus(input logic ic_r, input logic [31:0] ic_a,
                               input logic dc_r, input logic dc_w,
                               input logic [31:0] dc_a, input logic ack,
                               input logic r);
    ic_req  = ic_r;
    ic_addr = ic_a;
    dc_req  = dc_r;
    dc_we   = dc_w;
    dc_addr = dc_a;
    mem_ack = ack;
    rst     = r;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0]  ack_pat;
    logic [31:0] exp_addr;
    int          wcnt;
    int          rv_count;

    wb_mode = 1'b1;
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 1);
    next_cycle();

    // Reset state, with an ack that must be ignored in IDLE
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0);
    checkOutput("rst_mem_req",   {31'd0, mem_req},   32'd0);
    checkOutput("rst_mem_we",    {31'd0, mem_we},    32'd0);
    checkOutput("rst_mem_addr",  mem_addr,           32'd0);
    checkOutput("rst_mem_wdata", mem_wdata,          32'd0);
    checkOutput("rst_ic_rvalid", {31'd0, ic_rvalid}, 32'd0);
    checkOutput("rst_dc_rvalid", {31'd0, dc_rvalid}, 32'd0);
    checkOutput("rst_ic_done",   {31'd0, ic_done},   32'd0);
    checkOutput("rst_dc_done",   {31'd0, dc_done},   32'd0);
    next_cycle();
    wb_mode = 1'b0;

    // Single I-cache burst; address changes mid-burst must be ignored
    applyStimulus(1, 32'h0000_1004, 0, 0, 32'h0, 1, 0);
    checkOutput("ic_idle_req", {31'd0, mem_req}, 32'd0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, (i == 0) ? 32'h0000_1004 : 32'hFFFF_0000, 0, 0, 32'h0, 1, 0);
      exp_addr = 32'h0000_1000 + 32'(4 * i);
      checkOutput("ic_mem_req",   {31'd0, mem_req},   32'd1);
      checkOutput("ic_mem_addr",  mem_addr,           exp_addr);
      checkOutput("ic_rvalid",    {31'd0, ic_rvalid}, 32'd1);
      checkOutput("ic_rdata",     ic_rdata,           exp_addr ^ 32'h5A5A_0000);
      checkOutput("ic_dc_rvalid", {31'd0, dc_rvalid}, 32'd0);
      checkOutput("ic_done",      {31'd0, ic_done},   (i == 3) ? 32'd1 : 32'd0);
      next_cycle();
    end
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0);
    checkOutput("ic_after_req",  {31'd0, mem_req}, 32'd0);
    checkOutput("ic_after_done", {31'd0, ic_done}, 32'd0);
    next_cycle();

    // Simultaneous requests after reset: D-cache first, one IDLE cycle, then I-cache
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 1);
    next_cycle();
    applyStimulus(1, 32'h0000_4000, 1, 0, 32'h0000_3000, 1, 0);
    checkOutput("rr_idle0_req", {31'd0, mem_req}, 32'd0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 32'h0000_4000, 1, 0, 32'h0000_3000, 1, 0);
      exp_addr = 32'h0000_3000 + 32'(4 * i);
      checkOutput("rr_dc_addr",    mem_addr,           exp_addr);
      checkOutput("rr_dc_we",      {31'd0, mem_we},    32'd0);
      checkOutput("rr_dc_rvalid",  {31'd0, dc_rvalid}, 32'd1);
      checkOutput("rr_dc_rdata",   dc_rdata,           exp_addr ^ 32'h5A5A_0000);
      checkOutput("rr_dc_icvalid", {31'd0, ic_rvalid}, 32'd0);
      checkOutput("rr_dc_done",    {31'd0, dc_done},   (i == 3) ? 32'd1 : 32'd0);
      next_cycle();
    end
    applyStimulus(1, 32'h0000_4000, 1, 0, 32'h0000_3000, 1, 0);
    checkOutput("rr_gap_req",  {31'd0, mem_req}, 32'd0);
    checkOutput("rr_gap_done", {31'd0, dc_done}, 32'd0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 32'h0000_4000, 1, 0, 32'h0000_3000, 1, 0);
      checkOutput("rr_ic_addr",   mem_addr,           32'h0000_4000 + 32'(4 * i));
      checkOutput("rr_ic_rvalid", {31'd0, ic_rvalid}, 32'd1);
      checkOutput("rr_ic_done",   {31'd0, ic_done},   (i == 3) ? 32'd1 : 32'd0);
      next_cycle();
    end
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0);
    checkOutput("rr_end_req", {31'd0, mem_req}, 32'd0);
    next_cycle();

    // D-cache write-back; dc_we flipping mid-burst must be ignored
    wb_mode = 1'b1;
    applyStimulus(0, 32'h0, 1, 1, 32'h0000_2000, 1, 0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 32'h0, 1, (i == 0), 32'h0000_2000, 1, 0);
      checkOutput("wb_mem_we",    {31'd0, mem_we},    32'd1);
      checkOutput("wb_mem_addr",  mem_addr,           32'h0000_2000 + 32'(4 * i));
      checkOutput("wb_widx",      {30'd0, dc_widx},   32'(i));
      checkOutput("wb_mem_wdata", mem_wdata,          32'h0000_00A0 + 32'(i));
      checkOutput("wb_dc_rvalid", {31'd0, dc_rvalid}, 32'd0);
      checkOutput("wb_dc_done",   {31'd0, dc_done},   (i == 3) ? 32'd1 : 32'd0);
      next_cycle();
    end
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0);
    checkOutput("wb_idle_we",    {31'd0, mem_we},  32'd0);
    checkOutput("wb_idle_wdata", mem_wdata,        32'd0);
    next_cycle();
    wb_mode = 1'b0;

    // Wait states: ack pattern 1,0,0,1,1,0,1; request dropped mid-burst
    applyStimulus(1, 32'h0000_5000, 0, 0, 32'h0, 0, 0);
    next_cycle();
    ack_pat  = 7'b1011001;
    wcnt     = 0;
    rv_count = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus((i < 2), 32'h0000_5000, 0, 0, 32'h0, ack_pat[i], 0);
      checkOutput("ws_mem_req",  {31'd0, mem_req},   32'd1);
      checkOutput("ws_mem_addr", mem_addr,           32'h0000_5000 + 32'(4 * wcnt));
      checkOutput("ws_rvalid",   {31'd0, ic_rvalid}, {31'd0, ack_pat[i]});
      checkOutput("ws_done",     {31'd0, ic_done},   (i == 6) ? 32'd1 : 32'd0);
      if (ic_rvalid) rv_count++;
      if (ack_pat[i]) wcnt++;
      next_cycle();
    end
    checkOutput("ws_rvalid_count", 32'(rv_count), 32'd4);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0);
    checkOutput("ws_idle_req", {31'd0, mem_req}, 32'd0);
    next_cycle();

    // Reset after the second ack; the next request restarts from word 0
    applyStimulus(1, 32'h0000_6000, 0, 0, 32'h0, 1, 0);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 32'h0000_6000, 0, 0, 32'h0, 1, 0);
      checkOutput("mr_pre_addr", mem_addr, 32'h0000_6000 + 32'(4 * i));
      next_cycle();
    end
    applyStimulus(1, 32'h0000_6000, 0, 0, 32'h0, 1, 1);
    checkOutput("mr_rst_done", {31'd0, ic_done}, 32'd0);
    next_cycle();
    applyStimulus(1, 32'h0000_6000, 0, 0, 32'h0, 1, 0);
    checkOutput("mr_post_req",  {31'd0, mem_req}, 32'd0);
    checkOutput("mr_post_addr", mem_addr,         32'd0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 32'h0000_6000, 0, 0, 32'h0, 1, 0);
      checkOutput("mr_new_addr", mem_addr,         32'h0000_6000 + 32'(4 * i));
      checkOutput("mr_new_done", {31'd0, ic_done}, (i == 3) ? 32'd1 : 32'd0);
      next_cycle();
    end
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0);
    next_cycle();

    // Reset coinciding with the fourth ack must not produce done
    applyStimulus(0, 32'h0, 1, 0, 32'h0000_7000, 1, 0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 32'h0, 1, 0, 32'h0000_7000, 1, 0);
      checkOutput("rd_addr", mem_addr, 32'h0000_7000 + 32'(4 * i));
      next_cycle();
    end
    applyStimulus(0, 32'h0, 1, 0, 32'h0000_7000, 1, 1);
    checkOutput("rd_last_addr", mem_addr,         32'h0000_700C);
    checkOutput("rd_rst_done",  {31'd0, dc_done}, 32'd0);
    next_cycle();
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0);
    checkOutput("rd_idle_req",  {31'd0, mem_req}, 32'd0);
    checkOutput("rd_idle_addr", mem_addr,         32'd0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, words per cache-line burst; only 4 is supported.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter DATA_W, default 32, word width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset (`RstEnable`).
REQ-006 ic_req  in  1  I-cache line-refill request, held until ic_done.
REQ-007 ic_addr  in  ADDR_W  I-cache line address; bits [3:0] ignored.
REQ-008 ic_rdata  out  DATA_W  read word to I-cache.
REQ-009 ic_rvalid  out  1  ic_rdata valid this cycle.
REQ-010 ic_done  out  1  one-cycle pulse on the last word of an I-cache burst.
REQ-011 dc_req  in  1  D-cache request (refill or write-back), held until dc_done.
REQ-012 dc_we  in  1  1 = write-back burst, 0 = refill burst.
REQ-013 dc_addr  in  ADDR_W  D-cache line address; bits [3:0] ignored.
REQ-014 dc_wdata  in  DATA_W  write-back word selected by dc_widx.
REQ-015 dc_widx  out  2  index of the word currently being transferred.
REQ-016 dc_rdata / dc_rvalid / dc_done  out  DATA_W/1/1  same meaning as the ic_* equivalents.
REQ-017 mem_req / mem_we  out  1/1  memory transfer request and write enable.
REQ-018 mem_addr / mem_wdata  out  ADDR_W/DATA_W  memory word address and write data.
REQ-019 mem_rdata / mem_ack  in  DATA_W/1  read data and per-word completion.

Function
REQ-020 FSM states SHALL be IDLE, GNT_IC and GNT_DC; the word counter cnt SHALL be 2 bits.
REQ-021 IDLE: if only one requester is pending, that requester SHALL be granted at the next edge, with cnt cleared.
REQ-022 IDLE, both pending: dcache SHALL win unless the last completed grant was dcache; then icache SHALL win (round-robin). The last-grant bit SHALL reset to icache, so dcache wins first.
REQ-023 In a GNT state: mem_req=1; mem_we = dc_we in GNT_DC, else 0; mem_addr = {latched line addr[ADDR_W-1:4], cnt, 2'b00}; mem_wdata = dc_wdata; dc_widx = cnt.
REQ-024 Line address and dc_we SHALL be latched at the grant edge; requester input changes mid-burst SHALL be ignored.
REQ-025 A word SHALL complete in any cycle with mem_req && mem_ack; cnt SHALL increment at that edge, wrapping 3->0.
REQ-026 rvalid: ic_rvalid = GNT_IC && mem_ack; dc_rvalid = GNT_DC && mem_ack && !dc_we (combinational). rdata outputs SHALL pass mem_rdata through.
REQ-027 The done of the granted side SHALL pulse combinationally in the cycle of the 4th ack (cnt==3), for both read and write bursts.
REQ-028 After the 4th ack the FSM SHALL return to IDLE and stay there at least one cycle; mem_req SHALL be 0 in that cycle.
REQ-029 Dropping a request mid-burst SHALL NOT abort the burst; the burst SHALL complete and done SHALL pulse.
REQ-030 mem_ack while in IDLE SHALL be ignored.
REQ-031 Minimum burst latency: grant edge + 4 cycles (ack every cycle); wait states from mem_ack=0 SHALL stretch the burst with no bound.
REQ-032 In IDLE: mem_req, mem_we, all rvalid and all done = 0; mem_addr, mem_wdata = 0.

Reset
REQ-033 rst=1 at an edge SHALL force IDLE, cnt=0, last-grant=icache and the latched address to 0, including mid-burst.
REQ-034 From the cycle after that edge, all outputs SHALL hold their IDLE values (REQ-032).
REQ-035 An ack that coincides with the rst edge SHALL produce no done.

Verification
REQ-036 ic_req with ic_addr=0x00001004, mem_ack always 1 -> mem_addr 0x1000, 0x1004, 0x1008, 0x100C on 4 consecutive cycles; ic_done in cycle 4; mem_req=0 in the next cycle.
REQ-037 ic_req and dc_req raised together after reset, both held -> dcache burst first, then one IDLE cycle, then icache burst.
REQ-038 dc_req, dc_we=1, addr 0x2000, dc_wdata=0xA0+dc_widx -> mem_we=1 and mem_wdata 0xA0..0xA3 paired with addresses 0x2000..0x200C; dc_rvalid never 1.
REQ-039 mem_ack pattern 1,0,0,1,1,0,1 -> exactly 4 rvalid pulses; done on the 7th cycle; cnt holds through the 0 cycles.
REQ-040 rst asserted after the 2nd ack of a burst -> no done; mem_req=0 next cycle; a new ic_req restarts from word 0.
